// File: rtl/rf_multiport.sv
// rf_multiport: multi-port register file with a load-pending scoreboard; define RF_BYPASS_EN for write-through forwarding.
module rf_multiport #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          use1,
  input  logic          use2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we_a,
  input  logic [AW-1:0] wa_a,
  input  logic [DW-1:0] wd_a,
  input  logic          we_b,
  input  logic [AW-1:0] wa_b,
  input  logic [DW-1:0] wd_b,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_addr,
  output logic          busy1,
  output logic          busy2,
  output logic          hazard,
  output logic [AW:0]   pend_cnt
);
  localparam int N = 2**AW;
  localparam bit ZR = ZERO_REG != 0;
  logic [DW-1:0] rf [N];
  logic [N-1:0] busy, busy_nxt;
  logic wa_en, wb_en, sb_en, inc, dec, zr1, zr2;
  assign wa_en = we_a & ~(ZR && wa_a == '0);
  assign wb_en = we_b & ~(ZR && wa_b == '0);
  assign sb_en = sb_set & ~(ZR && sb_addr == '0);
  assign zr1 = ZR && ra1 == '0;
  assign zr2 = ZR && ra2 == '0;
  // a set and a clear on the same busy register cancel out, so only count real transitions
  assign inc = sb_en & ~busy[sb_addr];
  assign dec = wb_en & busy[wa_b] & ~(sb_en && sb_addr == wa_b);
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wa_b] = 1'b0;
    if (sb_en) busy_nxt[sb_addr] = 1'b1;
  end
`ifdef RF_BYPASS_EN
  assign rd1 = zr1 ? '0 : (wa_en && wa_a == ra1) ? wd_a : (wb_en && wa_b == ra1) ? wd_b : rf[ra1];
  assign rd2 = zr2 ? '0 : (wa_en && wa_a == ra2) ? wd_a : (wb_en && wa_b == ra2) ? wd_b : rf[ra2];
  assign busy1 = ~zr1 & busy[ra1] & ~(wb_en && wa_b == ra1 && !(sb_en && sb_addr == ra1));
  assign busy2 = ~zr2 & busy[ra2] & ~(wb_en && wa_b == ra2 && !(sb_en && sb_addr == ra2));
`else
  assign rd1 = zr1 ? '0 : rf[ra1];
  assign rd2 = zr2 ? '0 : rf[ra2];
  assign busy1 = ~zr1 & busy[ra1];
  assign busy2 = ~zr2 & busy[ra2];
`endif
  assign hazard = (busy1 & use1) | (busy2 & use2);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf <= '{default: '0};
      busy <= '0;
      pend_cnt <= '0;
    end else begin
      if (wb_en) rf[wa_b] <= wd_b;
      if (wa_en) rf[wa_a] <= wd_a;
      busy <= busy_nxt;
      pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed checks of rf_multiport, plus a ZERO_REG=0 instance for register-0 behaviour.
module tb_rf_multiport;
  logic clk = 0, reset = 0;
  logic [4:0] ra1 = 0, ra2 = 0, wa_a = 0, wa_b = 0, sb_addr = 0;
  logic use1 = 0, use2 = 0, we_a = 0, we_b = 0, sb_set = 0;
  logic [31:0] wd_a = 0, wd_b = 0;
  logic [31:0] rd1, rd2, rd1_nz, rd2_nz;
  logic busy1, busy2, hazard, busy1_nz, busy2_nz, hazard_nz;
  logic [5:0] pend_cnt, pend_nz;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rf_multiport #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
    .rd1(rd1), .rd2(rd2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1), .busy2(busy2), .hazard(hazard), .pend_cnt(pend_cnt));

  rf_multiport #(.DW(32), .AW(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
    .rd1(rd1_nz), .rd2(rd2_nz), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1_nz), .busy2(busy2_nz), .hazard(hazard_nz), .pend_cnt(pend_nz));

  task automatic idle();
    we_a = 0; we_b = 0; sb_set = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    ra1 = 5; ra2 = 0;
    #3;
    checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy1, busy2); end
    checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
    reset = 1;
  endtask

  task automatic test_write_a();
    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF; ra1 = 5;
    cyc();
    checks++; if (rd1 !== 32'hDEADBEEF) begin failures++; $display("FAIL write_a rd1=%h exp=deadbeef", rd1); end
    we_a = 1; wa_a = 0; wd_a = 32'h1234; ra1 = 0;
    cyc();
    checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL zero_reg rd1=%h exp=0", rd1); end
    checks++; if (rd1_nz !== 32'h1234) begin failures++; $display("FAIL no_zero_reg rd1=%h exp=1234", rd1_nz); end
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_addr = 3;
    cyc();
    sb_set = 1; sb_addr = 7;
    cyc();
    checks++; if (pend_cnt !== 6'd2) begin failures++; $display("FAIL sb_pend2 got=%0d exp=2", pend_cnt); end
    ra1 = 3; use1 = 1;
    #1;
    checks++; if (hazard !== 1'b1 || busy1 !== 1'b1) begin failures++; $display("FAIL sb_hazard got=%b/%b exp=1/1", hazard, busy1); end
    we_b = 1; wa_b = 3; wd_b = 32'h33;
    cyc();
    checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL sb_clear_pend got=%0d exp=1", pend_cnt); end
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h33) begin failures++; $display("FAIL sb_clear busy1=%b rd1=%h exp=0/33", busy1, rd1); end
    ra1 = 7; use1 = 0;
    #1;
    checks++; if (busy1 !== 1'b1 || hazard !== 1'b0) begin failures++; $display("FAIL sb_nouse busy1=%b hazard=%b exp=1/0", busy1, hazard); end
  endtask

  task automatic test_set_clear();
    sb_set = 1; sb_addr = 9;
    cyc();
    checks++; if (pend_cnt !== 6'd2) begin failures++; $display("FAIL set9_pend got=%0d exp=2", pend_cnt); end
    sb_set = 1; sb_addr = 9; we_b = 1; wa_b = 9; wd_b = 32'h99;
    cyc();
    ra1 = 9;
    #1;
    checks++; if (busy1 !== 1'b1 || pend_cnt !== 6'd2) begin failures++; $display("FAIL set_wins busy=%b pend=%0d exp=1/2", busy1, pend_cnt); end
    sb_set = 1; sb_addr = 4; we_b = 1; wa_b = 7; wd_b = 32'h77;
    cyc();
    ra1 = 4; ra2 = 7;
    #1;
    checks++; if (pend_cnt !== 6'd2) begin failures++; $display("FAIL swap_pend got=%0d exp=2", pend_cnt); end
    checks++; if (busy1 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL swap_busy got=%b%b exp=10", busy1, busy2); end
    sb_set = 1; sb_addr = 4; we_b = 1; wa_b = 10; wd_b = 32'hAA;
    cyc();
    ra2 = 10;
    #1;
    checks++; if (pend_cnt !== 6'd2 || busy1 !== 1'b1 || busy2 !== 1'b0 || rd2 !== 32'hAA) begin failures++; $display("FAIL redundant pend=%0d busy=%b%b rd2=%h exp=2/10/aa", pend_cnt, busy1, busy2, rd2); end
  endtask

  task automatic test_collision();
    sb_set = 1; sb_addr = 2;
    cyc();
    checks++; if (pend_cnt !== 6'd3) begin failures++; $display("FAIL coll_pre_pend got=%0d exp=3", pend_cnt); end
    we_a = 1; wa_a = 2; wd_a = 32'h11; we_b = 1; wa_b = 2; wd_b = 32'h22;
    cyc();
    ra1 = 2;
    #1;
    checks++; if (rd1 !== 32'h11) begin failures++; $display("FAIL coll_data got=%h exp=11", rd1); end
    checks++; if (busy1 !== 1'b0 || pend_cnt !== 6'd2) begin failures++; $display("FAIL coll_busy busy=%b pend=%0d exp=0/2", busy1, pend_cnt); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic exp_b;
    we_a = 1; wa_a = 6; wd_a = 32'hA5; ra2 = 6;
`ifdef RF_BYPASS_EN
    exp_rd = 32'hA5;
`else
    exp_rd = 32'h0;
`endif
    #1;
    checks++; if (rd2 !== exp_rd) begin failures++; $display("FAIL bypass_same got=%h exp=%h", rd2, exp_rd); end
    cyc();
    checks++; if (rd2 !== 32'hA5) begin failures++; $display("FAIL bypass_next got=%h exp=a5", rd2); end
    ra1 = 9; we_b = 1; wa_b = 9; wd_b = 32'h90;
`ifdef RF_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    #1;
    checks++; if (busy1 !== exp_b) begin failures++; $display("FAIL bypass_busy got=%b exp=%b", busy1, exp_b); end
    cyc();
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h90 || pend_cnt !== 6'd1) begin failures++; $display("FAIL clr9 busy=%b rd1=%h pend=%0d exp=0/90/1", busy1, rd1, pend_cnt); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) begin
      sb_set = 1; sb_addr = 5'(i);
      cyc();
    end
    checks++; if (pend_cnt !== 6'd31) begin failures++; $display("FAIL full_pend got=%0d exp=31", pend_cnt); end
    checks++; if (pend_nz !== 6'd32) begin failures++; $display("FAIL full_pend_nz got=%0d exp=32", pend_nz); end
    ra1 = 0; ra2 = 31;
    #1;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b1) begin failures++; $display("FAIL full_busy got=%b%b exp=01", busy1, busy2); end
  endtask

  task automatic test_async_reset();
    ra1 = 5; ra2 = 31;
    @(negedge clk);
    we_a = 1; wa_a = 8; wd_a = 32'h88; sb_set = 1; sb_addr = 8;
    #1;
    reset = 0;
    #1;
    checks++; if (pend_cnt !== 6'd0 || rd1 !== 32'h0 || busy2 !== 1'b0) begin failures++; $display("FAIL async_reset pend=%0d rd1=%h busy2=%b exp=0/0/0", pend_cnt, rd1, busy2); end
    @(posedge clk);
    #1;
    idle();
    reset = 1;
    ra1 = 8;
    #1;
    checks++; if (rd1 !== 32'h0 || busy1 !== 1'b0 || pend_cnt !== 6'd0) begin failures++; $display("FAIL reset_lost rd1=%h busy1=%b pend=%0d exp=0/0/0", rd1, busy1, pend_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_scoreboard();
    test_set_clear();
    test_collision();
    test_bypass();
    test_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
